// File: rtl/cvtsw_normalize.sv
// cvt.s.w front stage: sign/magnitude, binary-search normalise, biased exponent; latency 1+LOG2N (zero: 1).
// Holds result while out_ready is low (in_ready=0); optional CVTSW_UNSIGNED_EN adds uns_in for cvt.s.wu.
module cvtsw_normalize #(
    parameter int INTn    = 32,
    parameter int LOG2N   = 5,
    parameter int NEXP    = 8,
    parameter int BIAS    = 127,
    parameter int LAST_RA = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INTn-1:0]    in_int,
    input  logic [LAST_RA:0]   in_ra,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_neg,
    output logic [NEXP-1:0]    out_exp,
    output logic [INTn-1:0]    out_sig,
    output logic [LAST_RA:0]   out_ra,
    output logic               out_zero,
`ifdef CVTSW_UNSIGNED_EN
    input  logic               uns_in,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [NEXP-1:0]  EXP_TOP = NEXP'(BIAS + INTn - 1);
    localparam logic [LOG2N-1:0] K_INIT  = LOG2N'(LOG2N - 1);

    state_t             r_state, w_state_nx;
    logic [INTn-1:0]    r_mag;
    logic [LOG2N-1:0]   r_lzc;
    logic [LOG2N-1:0]   r_k;
    logic               r_neg;
    logic               r_zero;
    logic [NEXP-1:0]    r_exp;
    logic [LAST_RA:0]   r_ra;

    logic               w_acc;
    logic               w_neg;
    logic [INTn-1:0]    w_mag;
    logic [LOG2N-1:0]   w_step;
    logic [INTn-1:0]    w_mask;
    logic               w_hit;
    logic [INTn-1:0]    w_mag_sh;
    logic [LOG2N-1:0]   w_lzc_nx;
    logic [NEXP-1:0]    w_exp_nx;

`ifdef CVTSW_UNSIGNED_EN
    assign w_neg = ~uns_in & in_int[INTn-1];
`else
    assign w_neg = in_int[INTn-1];
`endif
    // Negation is modulo 2^INTn, so the most-negative input yields 2^(INTn-1).
    assign w_mag    = w_neg ? ({INTn{1'b0}} - in_int) : in_int;
    assign w_acc    = in_valid & in_ready;

    // Test the top 2^k bits of the magnitude; shift them out when all zero.
    assign w_step   = {{(LOG2N-1){1'b0}}, 1'b1} << r_k;
    assign w_mask   = ~({INTn{1'b1}} >> w_step);
    assign w_hit    = (r_mag & w_mask) == '0;
    assign w_mag_sh = w_hit ? (r_mag << w_step) : r_mag;
    assign w_lzc_nx = w_hit ? (r_lzc + w_step) : r_lzc;
    assign w_exp_nx = EXP_TOP - {{(NEXP-LOG2N){1'b0}}, w_lzc_nx};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_state_nx = (w_mag == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (r_k == '0) w_state_nx = S_DONE;
            S_DONE: begin
                if (w_acc)          w_state_nx = (w_mag == '0) ? S_DONE : S_SHIFT;
                else if (out_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag  <= '0;
            r_lzc  <= '0;
            r_k    <= '0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_exp  <= '0;
            r_ra   <= '0;
        end else if (w_acc) begin
            r_mag  <= w_mag;
            r_lzc  <= '0;
            r_k    <= K_INIT;
            r_neg  <= w_neg;
            r_zero <= (w_mag == '0);
            r_exp  <= '0;
            r_ra   <= in_ra;
        end else if (r_state == S_SHIFT) begin
            r_mag <= w_mag_sh;
            r_lzc <= w_lzc_nx;
            if (r_k == '0) r_exp <= w_exp_nx;
            else           r_k   <= r_k - 1'b1;
        end
    end

    assign out_neg  = r_neg;
    assign out_exp  = r_exp;
    assign out_sig  = r_mag;
    assign out_ra   = r_ra;
    assign out_zero = r_zero;

endmodule

// File: tb/tb_cvtsw_normalize.sv
// Bench for cvtsw_normalize: directed cases, back-pressure, mid-shift reset and random operands
// checked against a bit-serial leading-zero reference model.
module tb_cvtsw_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic [4:0]  in_ra;
    logic        out_valid;
    logic        out_ready;
    logic        out_neg;
    logic [7:0]  out_exp;
    logic [31:0] out_sig;
    logic [4:0]  out_ra;
    logic        out_zero;
    logic        busy;
`ifdef CVTSW_UNSIGNED_EN
    logic        uns_in;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cvtsw_normalize dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_int(in_int), .in_ra(in_ra),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_neg(out_neg), .out_exp(out_exp), .out_sig(out_sig), .out_ra(out_ra),
        .out_zero(out_zero),
`ifdef CVTSW_UNSIGNED_EN
        .uns_in(uns_in),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: strip leading zeros one bit at a time.
    task automatic model(input logic [31:0] v, input bit uns, output logic neg,
                         output logic [7:0] e, output logic [31:0] s, output logic z);
        logic [31:0] m;
        int lz;
        neg = !uns && v[31];
        m   = neg ? (32'd0 - v) : v;
        z   = (m == 32'd0);
        lz  = 0;
        if (z) begin
            e = 8'd0;
            s = 32'd0;
        end else begin
            while (!m[31]) begin
                m = m << 1;
                lz++;
            end
            e = 8'(158 - lz);
            s = m;
        end
    endtask

    task automatic wait_valid(input int exp_lat);
        int n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic chk_out(input logic [31:0] v, input bit uns, input logic [4:0] ra);
        logic en; logic [7:0] ee; logic [31:0] es; logic ez;
        model(v, uns, en, ee, es, ez);
        chk("out_valid", out_valid, 1);
        chk("out_neg", out_neg, en);
        chk("out_exp", out_exp, ee);
        chk("out_sig", out_sig, es);
        chk("out_zero", out_zero, ez);
        chk("out_ra", out_ra, ra);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [31:0] v, input logic [4:0] ra, input bit uns, input int stall);
        logic en; logic [7:0] ee; logic [31:0] es; logic ez;
        model(v, uns, en, ee, es, ez);
        in_valid = 1'b1; in_int = v; in_ra = ra; out_ready = (stall == 0);
`ifdef CVTSW_UNSIGNED_EN
        uns_in = uns;
`endif
        #1;
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_int = $urandom;
        wait_valid(ez ? 1 : 6);
        for (int i = 0; i < stall; i++) begin
            chk_out(v, uns, ra);
            chk("in_ready_stall", in_ready, 0);
            @(negedge clk);
        end
        chk_out(v, uns, ra);
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  ra;
        bit          uns;
        int          nv;
        rst = 1'b1; in_valid = 1'b0; in_int = '0; in_ra = '0; out_ready = 1'b1;
`ifdef CVTSW_UNSIGNED_EN
        uns_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sig", out_sig, 0);
        chk("rst_exp", out_exp, 0);
        chk("rst_neg", out_neg, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_ra", out_ra, 0);

        run_op(32'h0000_0001, 5'b00001, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 5'b00010, 1'b0, 0);
        run_op(32'h8000_0000, 5'b00100, 1'b0, 0);
        run_op(32'h0000_0000, 5'b01000, 1'b0, 0);

        // Held result under back-pressure, then back-to-back accept in the release cycle.
        in_valid = 1'b1; in_int = 32'h0001_2345; in_ra = 5'b10000; out_ready = 1'b0;
        @(negedge clk);
        in_int = $urandom;
        wait_valid(6);
        for (int i = 0; i < 10; i++) begin
            chk("hold_exp", out_exp, 8'd143);
            chk("hold_sig", out_sig, 32'h91A2_8000);
            chk("hold_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            in_int = $urandom;
            @(negedge clk);
        end
        in_int = 32'hFFFF_FFFB; in_ra = 5'b00001; out_ready = 1'b1;
        #1;
        chk("b2b_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_shift", out_valid, 0);
        wait_valid(6);
        chk_out(32'hFFFF_FFFB, 1'b0, 5'b00001);
        @(negedge clk);
        chk("b2b_drop", out_valid, 0);

        // Reset during the third SHIFT cycle discards the operand.
        in_valid = 1'b1; in_int = 32'h0000_0100; in_ra = 5'b00010;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_sig", out_sig, 0);
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("mrst_noout", 64'(nv), 0);

`ifdef CVTSW_UNSIGNED_EN
        run_op(32'hFFFF_FFFF, 5'b10000, 1'b1, 0);
        run_op(32'h8000_0000, 5'b00001, 1'b1, 1);
        run_op(32'h0000_0003, 5'b00100, 1'b1, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom;
                1:       v = 32'd0 - ($urandom >> $urandom_range(0, 31));
                2:       v = 32'd0;
                default: v = $urandom >> $urandom_range(0, 31);
            endcase
            ra = 5'b00001 << $urandom_range(0, 4);
`ifdef CVTSW_UNSIGNED_EN
            uns = 1'($urandom_range(0, 1));
`else
            uns = 1'b0;
`endif
            run_op(v, ra, uns, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
